// File: rtl/decoder_seq.sv
// Registered N-to-2^N one-hot decoder with enable, plus an optional scan
// sequencer that walks the one-hot output across every line once per request.
module decoder_seq #(
    parameter int WIDTH   = 2,
    parameter int SCAN_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in,
    input  logic                  en,
    input  logic                  scan_start,
    output logic [2**WIDTH-1:0]   out,
    output logic [WIDTH-1:0]      sel_q,
    output logic                  valid,
    output logic                  scan_busy,
    output logic                  scan_done
);

    localparam int               LINES = 2**WIDTH;
    localparam logic [WIDTH-1:0] LAST  = WIDTH'(LINES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  idx;
    logic [WIDTH-1:0]  idx_nxt;
    logic [LINES-1:0]  dec_out;
    logic [WIDTH-1:0]  dec_sel;

    function automatic logic [LINES-1:0] onehot(input logic [WIDTH-1:0] s);
        logic [LINES-1:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

    assign idx_nxt = idx + WIDTH'(1);

    // Gating on en first keeps an unknown select from reaching out while disabled.
    always_comb begin
        dec_out = '0;
        dec_sel = '0;
        if (en) begin
            dec_out = onehot(in);
            dec_sel = in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            out       <= '0;
            sel_q     <= '0;
            valid     <= 1'b0;
            scan_busy <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    scan_done <= 1'b0;
                    if ((SCAN_EN != 0) && scan_start) begin
                        state     <= SCAN;
                        idx       <= '0;
                        out       <= onehot('0);
                        sel_q     <= '0;
                        valid     <= 1'b1;
                        scan_busy <= 1'b1;
                    end else begin
                        out   <= dec_out;
                        sel_q <= dec_sel;
                        valid <= en;
                    end
                end
                SCAN: begin
                    // The terminal line hands over to DONE instead of wrapping.
                    if (idx != LAST) begin
                        idx   <= idx_nxt;
                        out   <= onehot(idx_nxt);
                        sel_q <= idx_nxt;
                        valid <= 1'b1;
                    end else begin
                        state     <= DONE;
                        idx       <= '0;
                        out       <= '0;
                        sel_q     <= '0;
                        valid     <= 1'b0;
                        scan_busy <= 1'b0;
                        scan_done <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    scan_done <= 1'b0;
                    out       <= dec_out;
                    sel_q     <= dec_sel;
                    valid     <= en;
                end
                default: begin
                    state     <= IDLE;
                    idx       <= '0;
                    out       <= '0;
                    sel_q     <= '0;
                    valid     <= 1'b0;
                    scan_busy <= 1'b0;
                    scan_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised registered N-to-2^N one-hot decoder with enable. Drives register-file write-enable and bus-select lines in the Virtual-CPU datapath.
- Adds a built-in scan sequencer: it walks the one-hot output through every line, one per cycle, for register-file clear and self-test after reset.
- Outputs are registered (1-cycle latency), unlike the purely combinational 2-to-4 decoder it generalises.

Parameters:
- WIDTH, 2, select width; output width is 2**WIDTH (derived, not overridable).
- SCAN_EN, 1, 1 = scan sequencer present; 0 = scan_start ignored, scan_busy and scan_done held 0.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in  input  WIDTH  select value for decode
- en  input  1  decode enable
- scan_start  input  1  request a scan sweep; sampled only in IDLE
- out  output  2**WIDTH  registered one-hot (or all-zero) select lines
- sel_q  output  WIDTH  index of the asserted out bit; 0 when out is all-zero
- valid  output  1  OR-reduction of out
- scan_busy  output  1  high while the sweep is driving out
- scan_done  output  1  one-cycle pulse after the sweep completes

Behaviour:
- Single clock domain. All state updates on the rising edge of clk. Reset is synchronous, active-high, and has priority over everything.
- Reset values:
  - out=0, sel_q=0, valid=0
  - scan_busy=0, scan_done=0
  - state=IDLE, scan index=0
- States: IDLE, SCAN, DONE.
- IDLE:
  - At each edge: out <= en ? (1 << in) : 0, and sel_q <= en ? in : 0.
  - Latency is exactly 1 cycle from input sample to out.
  - If scan_start=1 at an edge (and SCAN_EN=1): go to SCAN; out <= 1<<0; sel_q <= 0; scan_busy <= 1.
  - scan_start beats en when both are high in the same cycle.
- SCAN:
  - en, in and scan_start are ignored.
  - At each edge where index < 2**WIDTH-1: index increments and out <= 1<<index.
  - After index 2**WIDTH-1 has been driven for one cycle: go to DONE; out <= 0; sel_q <= 0; scan_busy <= 0; scan_done <= 1.
  - Each line is asserted for exactly 1 cycle, in ascending order. scan_busy is high for exactly 2**WIDTH cycles.
- DONE:
  - Lasts one cycle; out=0 during it; scan_done falls at the next edge.
  - At that edge, normal decode of en/in is applied and state returns to IDLE.
  - scan_start is ignored in DONE; it must be re-asserted in IDLE.
- Invariants:
  - out is always one-hot or all-zero, never multi-hot.
  - valid == |out.
  - sel_q is the log2 of out when valid=1.
- Reset mid-scan: aborts immediately, with no scan_done pulse. The next cycle is IDLE with all outputs 0.
- SCAN_EN=0: the block is a pure registered decoder; the SCAN and DONE states are unreachable.
- Wrap-around: the scan index never wraps. The terminal index 2**WIDTH-1 leads to DONE, not to index 0.
- Unknown (X) on in while en=0 must not propagate X to out.

Test Plan:
- WIDTH=2, en=1, in=00,01,10,11 on successive cycles -> out=0001,0010,0100,1000 each one cycle after its input; valid=1; sel_q=0,1,2,3.
- WIDTH=2, en=0, in swept 00..11 -> out=0000, valid=0, sel_q=0 every cycle. Then en=1, in=10 -> out=0100 one cycle later.
- WIDTH=2, scan_start=1 for one cycle at edge k -> out=0001,0010,0100,1000 at k+1..k+4; scan_busy=1 for k+1..k+4; at k+5 out=0000, scan_done=1. At k+6 out=decode(en,in), scan_done=0.
- WIDTH=2, scan_start=1 together with en=1, in=11 in IDLE -> out=0001 (scan wins). en=1, in=11 held during the scan has no effect until the edge after DONE, then out=1000.
- WIDTH=3, scan started, reset=1 at the cycle out=00001000 -> next cycle out=0, scan_busy=0, no scan_done pulse. A later scan covers all 8 lines in 8 cycles.
- WIDTH=4, SCAN_EN=0: scan_start pulsed with en=1, in=1010 -> out=0000_0100_0000_0000, scan_busy and scan_done stay 0. Random en/in for 1000 cycles -> out always one-hot or zero and matches a 1-cycle-delayed model.
